// File: rtl/lsu_axi_master.sv
// Bridges a single-outstanding core load/store request onto an AXI-lite master port.
// Every AXI valid/ready output comes straight from a flop, so no input reaches an output combinationally.
module lsu_axi_master #(
    parameter int DATA_LEN  = 32,
    parameter int STORB_LEN = 4,
    parameter int ADDR_LEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [ADDR_LEN-1:0]  req_addr,
    input  logic [DATA_LEN-1:0]  req_wdata,
    input  logic [STORB_LEN-1:0] req_wstrob,

    output logic                 resp_valid,
    output logic [DATA_LEN-1:0]  resp_rdata,
    output logic                 resp_err,

    output logic                 awvalid,
    input  logic                 awready,
    output logic [ADDR_LEN-1:0]  waddr,

    output logic                 wvalid,
    input  logic                 wready,
    output logic [DATA_LEN-1:0]  wdata,
    output logic [STORB_LEN-1:0] wstrob,

    input  logic                 bvalid,
    output logic                 bready,
    input  logic [2:0]           bresp,

    output logic                 arvalid,
    input  logic                 arready,
    output logic [ADDR_LEN-1:0]  raddr,

    input  logic                 rvalid,
    output logic                 rready,
    input  logic [DATA_LEN-1:0]  rdata,
    input  logic [2:0]           rresp
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   aw_done;
    logic                   aw_done_next;
    logic                   w_done;
    logic                   w_done_next;
    logic                   accept;
    logic                   done;

    logic                   wen_q;
    logic [ADDR_LEN-1:0]    addr_q;
    logic [DATA_LEN-1:0]    wdata_q;
    logic [STORB_LEN-1:0]   wstrob_q;

    assign req_ready = (state == IDLE);
    assign raddr     = addr_q;
    assign waddr     = addr_q;
    assign wdata     = wdata_q;
    assign wstrob    = wstrob_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    always_comb begin
        state_next   = state;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        accept       = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = req_wen ? WREQ : RADDR;
                end
            end
            RADDR: begin
                if (arvalid && arready) begin
                    state_next = RDATA;
                end
            end
            RDATA: begin
                if (rvalid && rready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            WREQ: begin
                // The two write handshakes may land in either order or together.
                if (awvalid && awready) begin
                    aw_done_next = 1'b1;
                end
                if (wvalid && wready) begin
                    w_done_next = 1'b1;
                end
                if (aw_done_next && w_done_next) begin
                    state_next   = WRESP;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            WRESP: begin
                if (bvalid && bready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            arvalid <= (state_next == RADDR);
            rready  <= (state_next == RDATA);
            awvalid <= (state_next == WREQ) && !aw_done_next;
            wvalid  <= (state_next == WREQ) && !w_done_next;
            bready  <= (state_next == WRESP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrob_q <= '0;
        end else if (accept) begin
            wen_q    <= req_wen;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wstrob_q <= req_wstrob;
        end
    end

    // Read data is only refreshed by read completions; the error flag by any completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= done;
            if (done) begin
                if (wen_q) begin
                    resp_err <= (bresp != 3'd0);
                end else begin
                    resp_err   <= (rresp != 3'd0);
                    resp_rdata <= rdata;
                end
            end
        end
    end

endmodule
